// File: rtl/udp_tx_scheduler_pkg.sv
// Shared types and constants for the UDP TX round-robin scheduler.
package udp_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StHdr     = 3'd1,
    StPayload = 3'd2,
    StDrain   = 3'd3,
    StDrop    = 3'd4,
    StGap     = 3'd5
  } state_e;

  localparam int unsigned UdpHdrLen  = 8;
  localparam logic [7:0]  DefaultTtl = 8'd64;

  function automatic logic [15:0] udp_length(input logic [15:0] payload_len);
    return payload_len + 16'(UdpHdrLen);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: first requester at or after ptr_i (wrapping) wins.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            gnt_valid_o
);

  always_comb begin
    int unsigned idx;
    logic        found;
    idx         = 0;
    found       = 1'b0;
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr_i) + i) % N;
      if (!found && req_i[IdxW'(idx)]) begin
        found              = 1'b1;
        gnt_o[IdxW'(idx)]  = 1'b1;
        gnt_idx_o          = IdxW'(idx);
      end
    end
    gnt_valid_o = found;
  end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Shares one UDP TX header/payload interface between N_SRC framed byte-stream requesters.
// Define UDP_TX_SCHED_STATS_EN to build the frame/drop/length-error counters.
module udp_tx_scheduler
  import udp_tx_scheduler_pkg::*;
#(
  parameter int unsigned N_SRC          = 2,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned MAX_LEN        = 1472,
  parameter int unsigned DEST_PORT_BASE = 1234,
  parameter logic [31:0] DEST_IP        = 32'hC0A8012F
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          local_ip,
  input  logic [15:0]          src_port,
  input  logic [8*N_SRC-1:0]   s_tdata,
  input  logic [N_SRC-1:0]     s_tvalid,
  input  logic [N_SRC-1:0]     s_tlast,
  input  logic [N_SRC-1:0]     s_tuser,
  output logic [N_SRC-1:0]     s_tready,
  input  logic [16*N_SRC-1:0]  s_len,
  output logic                 tx_udp_hdr_valid,
  input  logic                 tx_udp_hdr_ready,
  output logic [5:0]           tx_udp_ip_dscp,
  output logic [1:0]           tx_udp_ip_ecn,
  output logic [7:0]           tx_udp_ip_ttl,
  output logic [31:0]          tx_udp_ip_source_ip,
  output logic [31:0]          tx_udp_ip_dest_ip,
  output logic [15:0]          tx_udp_source_port,
  output logic [15:0]          tx_udp_dest_port,
  output logic [15:0]          tx_udp_length,
  output logic [15:0]          tx_udp_checksum,
  output logic [7:0]           tx_udp_payload_axis_tdata,
  output logic                 tx_udp_payload_axis_tvalid,
  output logic                 tx_udp_payload_axis_tlast,
  output logic                 tx_udp_payload_axis_tuser,
  input  logic                 tx_udp_payload_axis_tready,
  output logic [N_SRC-1:0]     grant,
  output logic                 len_err,
  output logic                 drop,
  output logic [31:0]          stat_frames,
  output logic [31:0]          stat_drops,
  output logic [31:0]          stat_len_errs
);

  localparam int unsigned IdxW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_SRC-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]   gidx_q, gidx_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       dest_port_q, dest_port_d;
  logic [15:0]       udp_len_q, udp_len_d;
  logic [15:0]       byte_cnt_q, byte_cnt_d;
  logic [15:0]       gap_cnt_q, gap_cnt_d;
  logic              len_err_q, len_err_d;
  logic              drop_q, drop_d;

  logic [N_SRC-1:0]  arb_gnt;
  logic [IdxW-1:0]   arb_idx;
  logic              arb_valid;
  logic [15:0]       sel_len;
  logic              last_byte;
  logic              src_valid;
  logic              src_last;
  logic              beat;

  rr_arbiter #(
    .N (N_SRC)
  ) u_rr_arbiter (
    .req_i       (s_tvalid),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (arb_gnt),
    .gnt_idx_o   (arb_idx),
    .gnt_valid_o (arb_valid)
  );

  assign sel_len   = s_len[{arb_idx, 4'b0000} +: 16];
  assign last_byte = (byte_cnt_q == len_q - 16'd1);
  assign src_valid = s_tvalid[gidx_q];
  assign src_last  = s_tlast[gidx_q];
  assign beat      = tx_udp_payload_axis_tvalid & tx_udp_payload_axis_tready;

  assign tx_udp_hdr_valid    = (state_q == StHdr);
  assign tx_udp_ip_dscp      = 6'd0;
  assign tx_udp_ip_ecn       = 2'd0;
  assign tx_udp_ip_ttl       = DefaultTtl;
  assign tx_udp_ip_source_ip = local_ip;
  assign tx_udp_ip_dest_ip   = DEST_IP;
  assign tx_udp_source_port  = src_port;
  assign tx_udp_dest_port    = dest_port_q;
  assign tx_udp_length       = udp_len_q;
  assign tx_udp_checksum     = 16'd0;
  assign grant               = grant_q;
  assign len_err             = len_err_q;
  assign drop                = drop_q;

  // Payload is a combinational pass-through of the granted source.
  always_comb begin
    s_tready                   = '0;
    tx_udp_payload_axis_tdata  = 8'd0;
    tx_udp_payload_axis_tvalid = 1'b0;
    tx_udp_payload_axis_tlast  = 1'b0;
    tx_udp_payload_axis_tuser  = 1'b0;
    case (state_q)
      StPayload: begin
        tx_udp_payload_axis_tdata  = s_tdata[{gidx_q, 3'b000} +: 8];
        tx_udp_payload_axis_tvalid = src_valid;
        tx_udp_payload_axis_tlast  = src_last | last_byte;
        tx_udp_payload_axis_tuser  = s_tuser[gidx_q] | (src_last & ~last_byte);
        s_tready[gidx_q]           = tx_udp_payload_axis_tready;
      end
      StDrain, StDrop: s_tready[gidx_q] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    len_d       = len_q;
    dest_port_d = dest_port_q;
    udp_len_d   = udp_len_q;
    byte_cnt_d  = byte_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    len_err_d   = 1'b0;
    drop_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (arb_valid) begin
          grant_d     = arb_gnt;
          gidx_d      = arb_idx;
          len_d       = sel_len;
          dest_port_d = 16'(DEST_PORT_BASE) + 16'(arb_idx);
          udp_len_d   = udp_length(sel_len);
          rr_ptr_d    = (arb_idx == IdxW'(N_SRC - 1)) ? '0 : arb_idx + IdxW'(1);
          if (sel_len != 16'd0 && 32'(sel_len) <= MAX_LEN) begin
            state_d = StHdr;
          end else begin
            state_d = StDrop;
            drop_d  = 1'b1;
          end
        end
      end
      StHdr: begin
        if (tx_udp_hdr_ready) begin
          state_d    = StPayload;
          byte_cnt_d = 16'd0;
        end
      end
      StPayload: begin
        if (beat) begin
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (last_byte && !src_last) begin
            // Declared length reached first: cut the frame, swallow the rest.
            state_d   = StDrain;
            len_err_d = 1'b1;
          end else if (last_byte || src_last) begin
            state_d   = StGap;
            gap_cnt_d = 16'd0;
            grant_d   = '0;
            len_err_d = ~last_byte;
          end
        end
      end
      StDrain, StDrop: begin
        if (src_valid && src_last) begin
          state_d   = StGap;
          gap_cnt_d = 16'd0;
          grant_d   = '0;
        end
      end
      StGap: begin
        if (32'(gap_cnt_q) + 32'd1 >= GAP_CYCLES) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      gidx_q      <= '0;
      len_q       <= 16'd0;
      dest_port_q <= 16'd0;
      udp_len_q   <= 16'd0;
      byte_cnt_q  <= 16'd0;
      gap_cnt_q   <= 16'd0;
      len_err_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      len_q       <= len_d;
      dest_port_q <= dest_port_d;
      udp_len_q   <= udp_len_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      len_err_q   <= len_err_d;
      drop_q      <= drop_d;
    end
  end

`ifdef UDP_TX_SCHED_STATS_EN
  logic [31:0] stat_frames_q, stat_frames_d;
  logic [31:0] stat_drops_q, stat_drops_d;
  logic [31:0] stat_len_errs_q, stat_len_errs_d;

  always_comb begin
    stat_frames_d   = stat_frames_q;
    stat_drops_d    = stat_drops_q;
    stat_len_errs_d = stat_len_errs_q;
    if (state_q == StPayload && state_d != StPayload) stat_frames_d = stat_frames_q + 32'd1;
    if (drop_d) stat_drops_d = stat_drops_q + 32'd1;
    if (len_err_d) stat_len_errs_d = stat_len_errs_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames_q   <= 32'd0;
      stat_drops_q    <= 32'd0;
      stat_len_errs_q <= 32'd0;
    end else begin
      stat_frames_q   <= stat_frames_d;
      stat_drops_q    <= stat_drops_d;
      stat_len_errs_q <= stat_len_errs_d;
    end
  end

  assign stat_frames   = stat_frames_q;
  assign stat_drops    = stat_drops_q;
  assign stat_len_errs = stat_len_errs_q;
`else
  assign stat_frames   = 32'd0;
  assign stat_drops    = 32'd0;
  assign stat_len_errs = 32'd0;
`endif

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Directed self-checking bench for udp_tx_scheduler (N_SRC=2, GAP_CYCLES=16).
module tb_udp_tx_scheduler;

  localparam int unsigned NSrc = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]         local_ip = 32'h0A000001;
  logic [15:0]         src_port = 16'd5000;
  logic [7:0]          d    [NSrc];
  logic                vld  [NSrc];
  logic                lst  [NSrc];
  logic                usr  [NSrc];
  logic [15:0]         slen [NSrc];
  logic [8*NSrc-1:0]   s_tdata;
  logic [NSrc-1:0]     s_tvalid, s_tlast, s_tuser, s_tready;
  logic [16*NSrc-1:0]  s_len;
  logic                hdr_valid, hdr_ready;
  logic [5:0]          dscp;
  logic [1:0]          ecn;
  logic [7:0]          ttl;
  logic [31:0]         sip, dip;
  logic [15:0]         sport, dport, ulen, csum;
  logic [7:0]          m_tdata;
  logic                m_tvalid, m_tlast, m_tuser, m_tready;
  logic [NSrc-1:0]     grant;
  logic                len_err, drop;
  logic [31:0]         stat_frames, stat_drops, stat_len_errs;

  for (genvar i = 0; i < NSrc; i++) begin : g_src
    assign s_tdata[8*i +: 8]  = d[i];
    assign s_tvalid[i]        = vld[i];
    assign s_tlast[i]         = lst[i];
    assign s_tuser[i]         = usr[i];
    assign s_len[16*i +: 16]  = slen[i];
  end

  udp_tx_scheduler #(
    .N_SRC      (NSrc),
    .GAP_CYCLES (16)
  ) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .local_ip                   (local_ip),
    .src_port                   (src_port),
    .s_tdata                    (s_tdata),
    .s_tvalid                   (s_tvalid),
    .s_tlast                    (s_tlast),
    .s_tuser                    (s_tuser),
    .s_tready                   (s_tready),
    .s_len                      (s_len),
    .tx_udp_hdr_valid           (hdr_valid),
    .tx_udp_hdr_ready           (hdr_ready),
    .tx_udp_ip_dscp             (dscp),
    .tx_udp_ip_ecn              (ecn),
    .tx_udp_ip_ttl              (ttl),
    .tx_udp_ip_source_ip        (sip),
    .tx_udp_ip_dest_ip          (dip),
    .tx_udp_source_port         (sport),
    .tx_udp_dest_port           (dport),
    .tx_udp_length              (ulen),
    .tx_udp_checksum            (csum),
    .tx_udp_payload_axis_tdata  (m_tdata),
    .tx_udp_payload_axis_tvalid (m_tvalid),
    .tx_udp_payload_axis_tlast  (m_tlast),
    .tx_udp_payload_axis_tuser  (m_tuser),
    .tx_udp_payload_axis_tready (m_tready),
    .grant                      (grant),
    .len_err                    (len_err),
    .drop                       (drop),
    .stat_frames                (stat_frames),
    .stat_drops                 (stat_drops),
    .stat_len_errs              (stat_len_errs)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: everything observed on the negative edge, away from the active edge.
  int              cyc = 0;
  int              len_err_cnt = 0;
  int              drop_cnt = 0;
  int              last_tlast_cyc = 0;
  logic [NSrc-1:0] prev_gnt = '0;
  logic [15:0]     hdr_port_q [$];
  logic [15:0]     hdr_len_q  [$];
  logic [9:0]      pay_q      [$];
  logic [NSrc-1:0] gnt_log    [$];
  int              gnt_cyc    [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (hdr_valid && hdr_ready) begin
      hdr_port_q.push_back(dport);
      hdr_len_q.push_back(ulen);
    end
    if (m_tvalid && m_tready) begin
      pay_q.push_back({m_tuser, m_tlast, m_tdata});
      if (m_tlast) last_tlast_cyc <= cyc;
    end
    if (grant != '0 && prev_gnt == '0) begin
      gnt_log.push_back(grant);
      gnt_cyc.push_back(cyc);
    end
    if (len_err) len_err_cnt <= len_err_cnt + 1;
    if (drop) drop_cnt <= drop_cnt + 1;
    prev_gnt <= grant;
  end

  logic [15:0]     exp_port [$];
  logic [15:0]     exp_len  [$];
  logic [9:0]      exp_pay  [$];
  logic [NSrc-1:0] exp_gnt  [$];

  function automatic logic [9:0] pe(input logic [7:0] b, input logic l, input logic u);
    return {u, l, b};
  endfunction

  task automatic wait_ready(input int s);
    int n;
    n = 0;
    @(negedge clk);
    while (!s_tready[s] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("ready_wait_timeout_src%0d", s), 32'(n >= 400), 32'd0);
  endtask

  task automatic send_frame(input int s, input logic [15:0] len, input int nbytes,
                            input logic [7:0] first);
    for (int b = 0; b < nbytes; b++) begin
      d[s]    = first + 8'(b);
      vld[s]  = 1'b1;
      lst[s]  = (b == nbytes - 1);
      usr[s]  = 1'b0;
      slen[s] = len;
      wait_ready(s);
      @(posedge clk);
      #1;
    end
    vld[s] = 1'b0;
    lst[s] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1_tlast;
    int n;
    for (int i = 0; i < NSrc; i++) begin
      d[i] = 8'd0; vld[i] = 1'b0; lst[i] = 1'b0; usr[i] = 1'b0; slen[i] = 16'd0;
    end
    hdr_ready = 1'b1;
    m_tready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_hdr_valid", 32'(hdr_valid), 32'd0);
    check_eq("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check_eq("rst_s_tready", 32'(s_tready), 32'd0);
    check_eq("rst_pulses", 32'({len_err, drop}), 32'd0);
    check_eq("rst_length", 32'(ulen), 32'd0);
    check_eq("const_ttl", 32'(ttl), 32'd64);
    check_eq("const_dscp_ecn_csum", 32'({dscp, ecn, csum}), 32'd0);
    check_eq("const_dest_ip", dip, 32'hC0A8012F);
    check_eq("const_source_ip", sip, 32'h0A000001);
    check_eq("const_source_port", 32'(sport), 32'd5000);
    check_eq("rst_stats", stat_frames | stat_drops | stat_len_errs, 32'd0);

    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic frame from source 0.
    send_frame(0, 16'd4, 4, 8'd11);
    t1_tlast = last_tlast_cyc;
    exp_port.push_back(16'd1234); exp_len.push_back(16'd12); exp_gnt.push_back(2'b01);
    exp_pay.push_back(pe(8'd11, 0, 0)); exp_pay.push_back(pe(8'd12, 0, 0));
    exp_pay.push_back(pe(8'd13, 0, 0)); exp_pay.push_back(pe(8'd14, 1, 0));

    // Both sources requesting; pointer now sits at 1 so source 1 goes first.
    fork
      begin
        send_frame(0, 16'd2, 2, 8'hA0);
        send_frame(0, 16'd2, 2, 8'hA2);
      end
      begin
        send_frame(1, 16'd2, 2, 8'hB0);
        send_frame(1, 16'd2, 2, 8'hB2);
      end
    join
    exp_gnt.push_back(2'b10); exp_gnt.push_back(2'b01);
    exp_gnt.push_back(2'b10); exp_gnt.push_back(2'b01);
    exp_port.push_back(16'd1235); exp_port.push_back(16'd1234);
    exp_port.push_back(16'd1235); exp_port.push_back(16'd1234);
    for (int i = 0; i < 4; i++) exp_len.push_back(16'd10);
    exp_pay.push_back(pe(8'hB0, 0, 0)); exp_pay.push_back(pe(8'hB1, 1, 0));
    exp_pay.push_back(pe(8'hA0, 0, 0)); exp_pay.push_back(pe(8'hA1, 1, 0));
    exp_pay.push_back(pe(8'hB2, 0, 0)); exp_pay.push_back(pe(8'hB3, 1, 0));
    exp_pay.push_back(pe(8'hA2, 0, 0)); exp_pay.push_back(pe(8'hA3, 1, 0));
    // tlast accepted at edge E: 16 GAP cycles, one IDLE cycle, grant registered at E+17.
    check_eq("gap_to_next_grant", 32'(gnt_cyc.size() > 1 ? gnt_cyc[1] - t1_tlast : 0), 32'd18);

    // Source 1 over-long: forced tlast on byte 3, bytes 4..5 drained.
    send_frame(1, 16'd3, 5, 8'h21);
    repeat (2) @(posedge clk);
    #1;
    check_eq("len_err_overlong", 32'(len_err_cnt), 32'd1);
    exp_gnt.push_back(2'b10); exp_port.push_back(16'd1235); exp_len.push_back(16'd11);
    exp_pay.push_back(pe(8'h21, 0, 0)); exp_pay.push_back(pe(8'h22, 0, 0));
    exp_pay.push_back(pe(8'h23, 1, 0));

    // Source 0 short: early tlast marked with tuser.
    send_frame(0, 16'd6, 2, 8'h31);
    repeat (2) @(posedge clk);
    #1;
    check_eq("len_err_short", 32'(len_err_cnt), 32'd2);
    check_eq("grant_cleared_in_gap", 32'(grant), 32'd0);
    exp_gnt.push_back(2'b01); exp_port.push_back(16'd1234); exp_len.push_back(16'd14);
    exp_pay.push_back(pe(8'h31, 0, 0)); exp_pay.push_back(pe(8'h32, 1, 1));

    // Illegal lengths: dropped without headers.
    send_frame(0, 16'd0, 2, 8'h51);
    send_frame(0, 16'd1500, 3, 8'h61);
    repeat (2) @(posedge clk);
    #1;
    exp_gnt.push_back(2'b01); exp_gnt.push_back(2'b01);
    check_eq("drop_pulses", 32'(drop_cnt), 32'd2);
    check_eq("len_err_after_drops", 32'(len_err_cnt), 32'd2);
    check_eq("hdr_count_after_drops", 32'(hdr_port_q.size()), 32'd7);
    check_eq("pay_count_after_drops", 32'(pay_q.size()), 32'd17);
`ifdef UDP_TX_SCHED_STATS_EN
    check_eq("stat_drops", stat_drops, 32'd2);
    check_eq("stat_frames", stat_frames, 32'd7);
    check_eq("stat_len_errs", stat_len_errs, 32'd2);
`else
    check_eq("stat_drops_absent", stat_drops, 32'd0);
    check_eq("stat_frames_absent", stat_frames, 32'd0);
    check_eq("stat_len_errs_absent", stat_len_errs, 32'd0);
`endif

    // Reset in PAYLOAD with the sink stalled.
    m_tready = 1'b0;
    d[0] = 8'hEE; vld[0] = 1'b1; lst[0] = 1'b0; slen[0] = 16'd4;
    n = 0;
    while (hdr_port_q.size() < 8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("stall_hdr_wait_timeout", 32'(n >= 200), 32'd0);
    exp_gnt.push_back(2'b01); exp_port.push_back(16'd1234); exp_len.push_back(16'd12);
    repeat (2) @(posedge clk);
    #1;
    check_eq("stall_m_tvalid_before_rst", 32'(m_tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    check_eq("midrst_grant", 32'(grant), 32'd0);
    check_eq("midrst_hdr_valid", 32'(hdr_valid), 32'd0);
    check_eq("midrst_m_tlast", 32'(m_tlast), 32'd0);
    check_eq("midrst_length", 32'(ulen), 32'd0);
    check_eq("midrst_stats", stat_frames | stat_drops | stat_len_errs, 32'd0);
    vld[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    m_tready = 1'b1;

    // Fresh pointer: source 0 wins even though source 1 was next before reset.
    fork
      send_frame(0, 16'd4, 4, 8'hC0);
      send_frame(1, 16'd2, 2, 8'hD0);
    join
    repeat (3) @(posedge clk);
    #1;
    exp_gnt.push_back(2'b01); exp_gnt.push_back(2'b10);
    exp_port.push_back(16'd1234); exp_len.push_back(16'd12);
    exp_port.push_back(16'd1235); exp_len.push_back(16'd10);
    exp_pay.push_back(pe(8'hC0, 0, 0)); exp_pay.push_back(pe(8'hC1, 0, 0));
    exp_pay.push_back(pe(8'hC2, 0, 0)); exp_pay.push_back(pe(8'hC3, 1, 0));
    exp_pay.push_back(pe(8'hD0, 0, 0)); exp_pay.push_back(pe(8'hD1, 1, 0));

    check_eq("hdr_count", 32'(hdr_port_q.size()), 32'(exp_port.size()));
    for (int i = 0; i < exp_port.size(); i++) begin
      check_eq($sformatf("hdr_port[%0d]", i),
               (i < hdr_port_q.size()) ? 32'(hdr_port_q[i]) : 32'hDEAD, 32'(exp_port[i]));
      check_eq($sformatf("hdr_len[%0d]", i),
               (i < hdr_len_q.size()) ? 32'(hdr_len_q[i]) : 32'hDEAD, 32'(exp_len[i]));
    end
    check_eq("pay_count", 32'(pay_q.size()), 32'(exp_pay.size()));
    for (int i = 0; i < exp_pay.size(); i++) begin
      check_eq($sformatf("pay[%0d]{tuser,tlast,data}", i),
               (i < pay_q.size()) ? 32'(pay_q[i]) : 32'hDEAD, 32'(exp_pay[i]));
    end
    check_eq("grant_count", 32'(gnt_log.size()), 32'(exp_gnt.size()));
    for (int i = 0; i < exp_gnt.size(); i++) begin
      check_eq($sformatf("grant[%0d]", i),
               (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'hDEAD, 32'(exp_gnt[i]));
    end
    check_eq("len_err_total", 32'(len_err_cnt), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
